// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, branch and memory-wait hazards,
// plus a debug halt/step sequencer and a saturating stall counter. Optional macro: STEP_EN.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             resume,
  input  logic             cnt_clr,
  output logic             pc_ena,
  output logic             if_id_ena,
  output logic             id_ex_ena,
  output logic             ex_mem_ena,
  output logic             mem_wb_ena,
  output logic             ctrl_ena,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

`ifdef STEP_EN
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, STEP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1} state_t;
  logic unused_step;
  assign unused_step = step_req;
`endif

  state_t state, state_nxt;
  logic   halt_pend, halt_pend_nxt;
  logic   lu, frz;

  assign lu  = ex_memtoreg & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign frz = mem_busy;

  // Priority decode: memory freeze, then branch flush, then load-use bubble.
  always_comb begin
    pc_ena      = 1'b0;
    if_id_ena   = 1'b0;
    id_ex_ena   = 1'b0;
    ex_mem_ena  = 1'b0;
    mem_wb_ena  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst && state != HALT) begin
      if (frz) begin
        pc_ena = 1'b0;
      end else if (ex_branch_taken) begin
        pc_ena      = 1'b1;
        if_id_ena   = 1'b1;
        id_ex_ena   = 1'b1;
        ex_mem_ena  = 1'b1;
        mem_wb_ena  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        id_ex_ena   = 1'b1;
        ex_mem_ena  = 1'b1;
        mem_wb_ena  = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_ena     = 1'b1;
        if_id_ena  = 1'b1;
        id_ex_ena  = 1'b1;
        ex_mem_ena = 1'b1;
        mem_wb_ena = 1'b1;
      end
    end
  end

  assign ctrl_ena = id_ex_ena;
  assign halted   = (state == HALT);

  always_comb begin
    state_nxt     = state;
    halt_pend_nxt = halt_pend;
    case (state)
      RUN: begin
        if ((halt_pend | halt_req) & !frz) begin
          state_nxt     = HALT;
          halt_pend_nxt = 1'b0;
        end else if (halt_req) begin
          halt_pend_nxt = 1'b1;
        end
      end
      HALT: begin
        halt_pend_nxt = 1'b0;
        if (resume) begin
          state_nxt = RUN;
`ifdef STEP_EN
        end else if (step_req) begin
          state_nxt = STEP;
`endif
        end
      end
`ifdef STEP_EN
      STEP: begin
        halt_pend_nxt = 1'b0;
        if (!frz) state_nxt = HALT;
      end
`endif
      default: begin
        state_nxt     = RUN;
        halt_pend_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      halt_pend <= halt_pend_nxt;
    end
  end

  // Lost cycles are those where the PC did not advance outside of a debug halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (cnt_clr) begin
      stall_count <= '0;
    end else if (state != HALT && !pc_ena && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic             ex_memtoreg = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0;
  logic             halt_req = 1'b0, step_req = 1'b0, resume = 1'b0, cnt_clr = 1'b0;
  logic             pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena, ctrl_ena;
  logic             if_id_flush, id_ex_flush, halted;
  logic [CNT_W-1:0] stall_count;

  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .halt_req(halt_req), .step_req(step_req), .resume(resume), .cnt_clr(cnt_clr),
    .pc_ena(pc_ena), .if_id_ena(if_id_ena), .id_ex_ena(id_ex_ena), .ex_mem_ena(ex_mem_ena),
    .mem_wb_ena(mem_wb_ena), .ctrl_ena(ctrl_ena), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Input flag bits: {rst, memtoreg, branch, busy, halt_req, step_req, resume, cnt_clr}
  localparam logic [7:0] NONE = 8'h00, R = 8'h80, MTR = 8'h40, BR = 8'h20, BUSY = 8'h10;
  localparam logic [7:0] HREQ = 8'h08, SREQ = 8'h04, RES = 8'h02, CLR = 8'h01;

  // Expected outputs: {pc,if_id,id_ex,ex_mem,mem_wb,ctrl, if_id_flush,id_ex_flush, halted}
  localparam logic [8:0] X_ALL  = {6'b111111, 2'b00, 1'b0};
  localparam logic [8:0] X_FRZ  = {6'b000000, 2'b00, 1'b0};
  localparam logic [8:0] X_LU   = {6'b001111, 2'b01, 1'b0};
  localparam logic [8:0] X_BR   = {6'b111111, 2'b11, 1'b0};
  localparam logic [8:0] X_HALT = {6'b000000, 2'b00, 1'b1};

  typedef struct {
    logic [8:0] sig;
    int         cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input string nm, input logic [7:0] f,
                     input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                     input logic [REG_W-1:0] ert, input logic [8:0] xs, input int xc);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, ex_memtoreg, ex_branch_taken, mem_busy, halt_req, step_req, resume, cnt_clr} = f;
    id_rs = rs;
    id_rt = rt;
    ex_rt = ert;
    e.sig = xs;
    e.cnt = xc;
    e.nm  = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [8:0] got;
      e   = q.pop_front();
      got = {pc_ena, if_id_ena, id_ex_ena, ex_mem_ena, mem_wb_ena, ctrl_ena,
             if_id_flush, id_ex_flush, halted};
      checks++;
      if (got !== e.sig) begin
        errors++;
        $display("FAIL %s outputs: got=%b expected=%b", e.nm, got, e.sig);
      end
      if (e.cnt >= 0) begin
        checks++;
        if (stall_count !== CNT_W'(e.cnt)) begin
          errors++;
          $display("FAIL %s stall_count: got=%0d expected=%0d", e.nm, stall_count, e.cnt);
        end
      end
    end
  end

  initial begin
    cyc("reset",        R,          0, 0, 0, X_FRZ, 0);
    cyc("idle",         NONE,       0, 0, 0, X_ALL, 0);
    cyc("lu_rs",        MTR,        8, 3, 8, X_LU,  0);
    cyc("lu_after",     NONE,       8, 3, 8, X_ALL, 1);
    cyc("lu_rt",        MTR,        2, 5, 5, X_LU,  1);
    cyc("r0_no_stall",  MTR,        0, 0, 0, X_ALL, 2);
    cyc("no_load",      NONE,       8, 8, 8, X_ALL, 2);
    cyc("br_over_lu",   MTR | BR,   8, 1, 8, X_BR,  2);
    for (int k = 0; k < 3; k++)
      cyc("frz_br",     BUSY | BR,  0, 0, 0, X_FRZ, 2 + k);
    cyc("br_after_frz", BR,         0, 0, 0, X_BR,  5);
    cyc("clr",          CLR,        0, 0, 0, X_ALL, 5);
    cyc("clr_after",    NONE,       0, 0, 0, X_ALL, 0);
    // Halt requested during a memory wait lands once the wait ends.
    cyc("hreq_frz",     HREQ | BUSY, 0, 0, 0, X_FRZ, 0);
    cyc("frz_pend",     BUSY,       0, 0, 0, X_FRZ, 1);
    cyc("busy_fell",    NONE,       0, 0, 0, X_ALL, 2);
    cyc("halt_hreq",    HREQ,       0, 0, 0, X_HALT, 2);
    cyc("halt_hold",    NONE,       0, 0, 0, X_HALT, 2);
`ifdef STEP_EN
    cyc("step_req",     SREQ,       0, 0, 0, X_HALT, 2);
    cyc("step_frz",     BUSY,       0, 0, 0, X_FRZ, 2);
    cyc("step_go",      NONE,       0, 0, 0, X_ALL, 3);
    cyc("step_back",    NONE,       0, 0, 0, X_HALT, 3);
    cyc("resume_wins",  RES | SREQ, 0, 0, 0, X_HALT, 3);
`else
    cyc("step_ignored", SREQ,       0, 0, 0, X_HALT, 2);
    cyc("still_halted", NONE,       0, 0, 0, X_HALT, 2);
    cyc("resume",       RES,        0, 0, 0, X_HALT, 2);
`endif
    cyc("run_again",    NONE,       0, 0, 0, X_ALL, -1);
    cyc("no_phantom",   CLR,        0, 0, 0, X_ALL, -1);
    cyc("hreq_direct",  HREQ,       0, 0, 0, X_ALL, 0);
    cyc("halt_direct",  NONE,       0, 0, 0, X_HALT, 0);
    cyc("resume2",      RES,        0, 0, 0, X_HALT, 0);
    cyc("run2",         NONE,       0, 0, 0, X_ALL, 0);
    for (int k = 0; k < 17; k++)
      cyc("sat_frz",    BUSY,       0, 0, 0, X_FRZ, (k > 15) ? 15 : k);
    cyc("sat_lu",       MTR,        4, 0, 4, X_LU,  15);
    cyc("sat_clr",      CLR,        0, 0, 0, X_ALL, 15);
    cyc("sat_cleared",  NONE,       0, 0, 0, X_ALL, 0);
    // Async reset in the middle of a freeze drops the pending halt.
    cyc("pend_frz",     HREQ | BUSY, 0, 0, 0, X_FRZ, 0);
    cyc("rst_mid",      R | BUSY,   0, 0, 0, X_FRZ, 0);
    cyc("rst_release",  NONE,       0, 0, 0, X_ALL, 0);
    cyc("pend_dropped", NONE,       0, 0, 0, X_ALL, 0);
    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
